// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, FSM encoding, state packing.
// Column k of a 128-bit state is bits [32k+31:32k]; byte 0 is bits [31:24].
package aes_pkg;

  localparam logic [7:0] RED = 8'h1b;
  localparam int COL_W  = 32;
  localparam int N_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] c);
    return {c[6:0], 1'b0} ^ (RED & {8{c[7]}});
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_word.sv
// Combinational InvMixColumns of one 32-bit column.
// Shared with the equivalent-inverse-cipher key schedule path.
module inv_mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] res
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign res[31:24] = gf_mul14(a0) ^ gf_mul11(a1)
                    ^ gf_mul13(a2) ^ gf_mul9(a3);
  assign res[23:16] = gf_mul9(a0)  ^ gf_mul14(a1)
                    ^ gf_mul11(a2) ^ gf_mul13(a3);
  assign res[15:8]  = gf_mul13(a0) ^ gf_mul9(a1)
                    ^ gf_mul14(a2) ^ gf_mul11(a3);
  assign res[7:0]   = gf_mul11(a0) ^ gf_mul13(a1)
                    ^ gf_mul9(a2)  ^ gf_mul14(a3);

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// Iterative InvMixColumns: one state in, COLS_PER_CYCLE columns per clock,
// result held on a valid/ready output until taken.
module inv_mixcolumns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam int C = COLS_PER_CYCLE;
  localparam logic [1:0] STEP = 2'(C);
  localparam logic [1:0] LAST = 2'(N_COLS - C);

  generate
    if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  state_e       st;
  logic [1:0]   col_cnt;
  logic [127:0] work;
  logic [127:0] nxt;
  logic [1:0]   idx  [C];
  logic [31:0]  cin  [C];
  logic [31:0]  cout [C];

  always_comb begin
    for (int j = 0; j < C; j++) begin
      idx[j] = col_cnt + 2'(j);
      cin[j] = work[idx[j]*COL_W +: COL_W];
    end
  end

  genvar g;
  generate
    for (g = 0; g < C; g++) begin : g_col
      inv_mixcolumn_word u_word (
        .col (cin[g]),
        .res (cout[g])
      );
    end
  endgenerate

  // Columns of the current group are replaced in place.
  always_comb begin
    nxt = work;
    for (int j = 0; j < C; j++) begin
      nxt[idx[j]*COL_W +: COL_W] = cout[j];
    end
  end

  assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      col_cnt   <= '0;
      work      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            work    <= state;
            col_cnt <= '0;
            st      <= BUSY;
          end
        end
        BUSY: begin
          work    <= nxt;
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST) begin
            out       <= nxt;
            out_valid <= 1'b1;
            col_cnt   <= '0;
            st        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work    <= state;
              col_cnt <= '0;
              st      <= BUSY;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Bench for inv_mixcolumns_iter at COLS_PER_CYCLE = 1, 2 and 4.
// A GF(2^8) matrix model feeds a per-instance scoreboard checked every cycle.
module tb_inv_mixcolumns_iter;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V2 = 128'hc6c6c6c6_c6c6c6c6_01010101_4d7ebdf8;
  localparam logic [127:0] E2 = 128'hc6c6c6c6_c6c6c6c6_01010101_2d26314c;
  localparam logic [127:0] V3 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] E3 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] iv = '0;
  logic [2:0] ordy = '1;
  logic [2:0] irdy;
  logic [2:0] ovld;
  logic [127:0] st_in [3];
  logic [127:0] ob [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] v;
    int acc;
  } exp_t;
  exp_t sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_mixcolumns_iter #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .state(st_in[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out(ob[0]));
  inv_mixcolumns_iter #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .state(st_in[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out(ob[1]));
  inv_mixcolumns_iter #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .state(st_in[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
    .out(ob[2]));

  function automatic int lat(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 1;
  endfunction

  // Carry-less product followed by polynomial reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] circ(input logic [127:0] s,
                                        input logic [31:0] coef);
    logic [127:0] r;
    logic [7:0] a [4];
    logic [7:0] c [4];
    logic [7:0] acc;
    r = '0;
    for (int k = 0; k < 4; k++) c[k] = coef[31-8*k -: 8];
    for (int col = 0; col < 4; col++) begin
      for (int k = 0; k < 4; k++) a[k] = s[32*col+31-8*k -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(a[k], c[(k - i + 4) % 4]);
        r[32*col+31-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_m(input logic [127:0] s);
    return circ(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] s);
    return circ(s, 32'h02030101);
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        sb[i].delete();
        chk("rst_out", ob[i], '0);
        chk("rst_valid", 128'(ovld[i]), 128'd0);
        chk("rst_ready", 128'(irdy[i]), 128'd1);
      end else begin
        logic ev;
        logic er;
        ev = (sb[i].size() > 0) && (cyc >= sb[i][0].acc + lat(i));
        er = (sb[i].size() == 0) ? 1'b1 : (ev ? ordy[i] : 1'b0);
        chk("out_valid", 128'(ovld[i]), 128'(ev));
        chk("in_ready", 128'(irdy[i]), 128'(er));
        if (ev) begin
          chk("out_data", ob[i], sb[i][0].v);
          if (ordy[i]) void'(sb[i].pop_front());
        end
        if (iv[i] && irdy[i])
          sb[i].push_back('{v: inv_m(st_in[i]), acc: cyc + 1});
      end
    end
  end

  task automatic send(input int i, input logic [127:0] s);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    st_in[i] = s;
    iv[i] = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = irdy[i];
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout inst %0d", i);
    end
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_out(input int i, input logic [127:0] lit);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = ovld[i];
    end
    if (!ok) begin
      errors++;
      $display("FAIL result_timeout inst %0d", i);
    end else begin
      chk("literal", ob[i], lit);
    end
  endtask

  initial begin
    logic [127:0] x;
    for (int i = 0; i < 3; i++) st_in[i] = '0;

    chk("model_v1", inv_m(V1), E1);
    chk("model_v2", inv_m(V2), E2);
    chk("model_v3", inv_m(V3), E3);
    chk("model_mix", mix_m(E1), V1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      send(i, V1);
      wait_out(i, E1);
      send(i, V2);
      wait_out(i, E2);
      send(i, V3);
      wait_out(i, E3);
    end

    // Back-pressure, then a back-to-back accept from DONE.
    ordy[0] = 1'b0;
    send(0, V1);
    wait_out(0, E1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out", ob[0], E1);
      chk("bp_ready", 128'(irdy[0]), 128'd0);
    end
    @(posedge clk);
    #1;
    st_in[0] = V2;
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 128'(irdy[0]), 128'd1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    wait_out(0, E2);

    // in_valid and state wiggle while busy.
    send(0, V1);
    for (int n = 0; n < 2; n++) begin
      st_in[0] = {$urandom, $urandom, $urandom, $urandom};
      iv[0] = ~iv[0];
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    wait_out(0, E1);
    repeat (6) @(posedge clk);

    // Reset two cycles into BUSY.
    send(0, V3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("amid_out", ob[0], '0);
    chk("amid_valid", 128'(ovld[0]), 128'd0);
    chk("amid_ready", 128'(irdy[0]), 128'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    send(0, V2);
    wait_out(0, E2);

    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(n % 3, mix_m(x));
      wait_out(n % 3, x);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/inv_mixcolumns_iter.md
Name: inv_mixcolumns_iter

Overview:
- AES InvMixColumns for the decryption datapath; the inverse of the encrypt-side MixColumns stage.
- Accepts one 128-bit state over a valid/ready handshake.
- Transforms it COLS_PER_CYCLE columns per clock through a shared column engine, then holds the result on a valid/ready output until it is taken.
- Sits between the inverse ShiftRows/SubBytes stages and AddRoundKey in the iterative decrypt round.

Parameters:
- COLS_PER_CYCLE, 1, number of 32-bit columns transformed per clock; legal values 1, 2, 4. Latency LAT = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  state is presented.
- in_ready  output  1  block can accept a state this cycle.
- state  input  128  input state; column k = state[32k+31:32k]; byte 0 of a column = bits [31:24].
- out_valid  output  1  out holds a completed result.
- out_ready  input  1  consumer takes out this cycle.
- out  output  128  result, same packing as state.

Behaviour:
- Column transform: per column, r0=14a0^11a1^13a2^9a3, r1=9a0^14a1^11a2^13a3, r2=13a0^9a1^14a2^11a3, r3=11a0^13a1^9a2^14a3.
  - Multiplication is in GF(2^8) with polynomial 0x11b; xtime(c)={c[6:0],0}^(0x1b & {8{c[7]}}).
  - All products are built from xtime chains; no lookup tables.
- Reset (async assert, sync deassert handled upstream) clears everything: FSM=IDLE, col_cnt=0, work register=0, out=0, out_valid=0, in_ready=1.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture state into the work register, col_cnt=0, go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - Each cycle, transform columns col_cnt..col_cnt+COLS_PER_CYCLE-1 in place; col_cnt += COLS_PER_CYCLE.
  - After the last group, load out, set out_valid=1 and go to DONE.
  - Exactly LAT cycles are spent in BUSY.
  - out_valid rises on the clock edge LAT cycles after the accepting edge: LAT=4 for COLS_PER_CYCLE=1, LAT=1 for 4.
- FSM DONE:
  - out_valid=1; out and out_valid hold stable while out_ready=0.
  - in_ready=out_ready, combinational pass-through that allows back-to-back operation.
  - On out_ready with in_valid: capture the new state, go to BUSY, out_valid falls next edge.
  - On out_ready without in_valid: go to IDLE, out_valid=0.
- col_cnt width is 2 bits and wraps to 0 on leaving BUSY; it is never observed outside BUSY.
- in_valid is ignored in BUSY; the upstream must hold the state until in_ready.
- state is sampled only on the accepting edge; later changes have no effect.
- Reset asserted mid-operation (BUSY or DONE) aborts immediately; the pending result is discarded and nothing is emitted after release.
- Illegal COLS_PER_CYCLE is an elaboration error (generate-time check).

Decomposition:
- Package aes_pkg:
  - xtime and gf_mul9/11/13/14 functions.
  - The 0x1b reduction constant.
  - The FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - The column/byte packing convention.
- Sub-module inv_mixcolumn_word:
  - Combinational 32-bit single-column transform; instantiated COLS_PER_CYCLE times.
  - Reused by the key-schedule equivalent-inverse-cipher path.

Test Plan:
- FIPS-197 column vectors, COLS_PER_CYCLE=1: state=128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out=128'hdb135345_f20a225c_01010101_d4d4d4d5, out_valid exactly 4 cycles after accept.
- Fixed points and one more vector: state=128'hc6c6c6c6_c6c6c6c6_01010101_4d7ebdf8 -> out=128'hc6c6c6c6_c6c6c6c6_01010101_2d26314c. Repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1) and require identical out.
- Round-trip: FIPS-197 round-1 MixColumns output 046681e5_e0cb199a_48f8d37a_2806264c, packed with column 0 in state[31:0] -> out equals d4bf5d30_e0b452ae_b84111f1_1e2798e5 in the same packing. Also run 1000 random states through the encrypt-side MixColumns and then this block, requiring identity.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out and out_valid stable, in_ready=0. Then assert out_ready with in_valid high -> new state accepted that same cycle, next result after LAT cycles.
- Busy stall: toggle in_valid and state during BUSY -> in_ready=0, the result reflects only the originally accepted state, no extra output.
- Reset mid-op: drop rst_n two cycles into BUSY -> out=0, out_valid=0, in_ready=1 immediately (asynchronous). After release, no stale result; the next accepted vector completes correctly.
